key_event_decoder: RTL and testbench

KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

---
 rtl/key_event_decoder.sv | 130 +++++++++++++
 tb/tb_key_event_decoder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_decoder.sv
// Key event decoder: turns debounced key edges into short/long/double-click pulses.
// Optional auto-repeat while held in LONG is enabled by defining KEY_REPEAT_EN.
module key_event_decoder #(
   parameter logic [25:0] LONG_CNT   = 26'd50_000_000,
   parameter logic [25:0] DCLK_CNT   = 26'd15_000_000,
   parameter logic [25:0] REPEAT_CNT = 26'd10_000_000
) (
   input  logic Clk,
   input  logic Rst_n,
   input  logic key_flag,
   input  logic key_state,
   output logic short_press,
   output logic long_press,
   output logic double_click,
   output logic key_repeat,
   output logic busy
);

   localparam logic [4:0] S_IDLE   = 5'b00001;
   localparam logic [4:0] S_PRESS1 = 5'b00010;
   localparam logic [4:0] S_WAIT2  = 5'b00100;
   localparam logic [4:0] S_PRESS2 = 5'b01000;
   localparam logic [4:0] S_LONG   = 5'b10000;

   // A zero threshold would make the cnt == X-1 compare alias the all-ones count.
   if (LONG_CNT == 26'd0 || DCLK_CNT == 26'd0 || REPEAT_CNT == 26'd0) begin : g_bad_threshold
      $error("key_event_decoder: thresholds must be non-zero");
   end

   logic [4:0]  state_q, state_d;
   logic [25:0] cnt_q, cnt_d;
   logic        short_press_q, short_press_d;
   logic        long_press_q, long_press_d;
   logic        double_click_q, double_click_d;
   logic        key_repeat_d;
   logic        busy_q, busy_d;
   logic        cnt_clr;
   logic        press_ev, release_ev;

   assign press_ev   = key_flag & ~key_state;
   assign release_ev = key_flag &  key_state;

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d        = state_q;
      short_press_d  = 1'b0;
      long_press_d   = 1'b0;
      double_click_d = 1'b0;
      key_repeat_d   = 1'b0;
      cnt_clr        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (press_ev) state_d = S_PRESS1;
         end
         S_PRESS1: begin
            if (release_ev) begin
               state_d = S_WAIT2;
            end else if (cnt_q == LONG_CNT - 26'd1) begin
               state_d      = S_LONG;
               long_press_d = 1'b1;
            end
         end
         S_WAIT2: begin
            if (press_ev) begin
               state_d = S_PRESS2;
            end else if (cnt_q == DCLK_CNT - 26'd1) begin
               state_d       = S_IDLE;
               short_press_d = 1'b1;
            end
         end
         S_PRESS2: begin
            if (release_ev) begin
               state_d        = S_IDLE;
               double_click_d = 1'b1;
            end
         end
         S_LONG: begin
            if (release_ev) begin
               state_d = S_IDLE;
`ifdef KEY_REPEAT_EN
            end else if (cnt_q == REPEAT_CNT - 26'd1) begin
               key_repeat_d = 1'b1;
               cnt_clr      = 1'b1;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
      cnt_d  = (state_d != state_q || cnt_clr) ? 26'd0 : cnt_q + 26'd1;
      busy_d = (state_d != S_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments only; all flops clear asynchronously.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q        <= S_IDLE;
         cnt_q          <= 26'd0;
         short_press_q  <= 1'b0;
         long_press_q   <= 1'b0;
         double_click_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         short_press_q  <= short_press_d;
         long_press_q   <= long_press_d;
         double_click_q <= double_click_d;
         busy_q         <= busy_d;
      end
   end

`ifdef KEY_REPEAT_EN
   logic key_repeat_q;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) key_repeat_q <= 1'b0;
      else        key_repeat_q <= key_repeat_d;
   end

   assign key_repeat = key_repeat_q;
`else
   assign key_repeat = key_repeat_d;
`endif

   assign short_press  = short_press_q;
   assign long_press   = long_press_q;
   assign double_click = double_click_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Scoreboard bench for key_event_decoder: expected pulses (kind, edge) are queued as
// stimulus is driven and popped by a monitor sampling outputs on the falling edge.
module tb_key_event_decoder;

   localparam logic [25:0] LONG_CNT   = 26'd100;
   localparam logic [25:0] DCLK_CNT   = 26'd30;
   localparam logic [25:0] REPEAT_CNT = 26'd20;
   localparam int L = 100, D = 30, R = 20;

   localparam int K_SHORT  = 1;
   localparam int K_LONG   = 2;
   localparam int K_DOUBLE = 3;
   localparam int K_REPEAT = 4;

   typedef struct {
      int kind;
      int edge_no;
   } exp_t;

   exp_t sb[$];

   logic Clk = 1'b0;
   logic Rst_n = 1'b0;
   logic key_flag = 1'b0;
   logic key_state = 1'b1;
   logic short_press, long_press, double_click, key_repeat, busy;

   int checks = 0;
   int errors = 0;
   int edge_n = 0;

   key_event_decoder #(
      .LONG_CNT  (LONG_CNT),
      .DCLK_CNT  (DCLK_CNT),
      .REPEAT_CNT(REPEAT_CNT)
   ) dut (
      .Clk         (Clk),
      .Rst_n       (Rst_n),
      .key_flag    (key_flag),
      .key_state   (key_state),
      .short_press (short_press),
      .long_press  (long_press),
      .double_click(double_click),
      .key_repeat  (key_repeat),
      .busy        (busy)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) edge_n <= edge_n + 1;

   task automatic check(input string tag, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, actual, expected, edge_n);
      end
   endtask

   task automatic push(input int kind, input int edge_no);
      exp_t e;
      e.kind    = kind;
      e.edge_no = edge_no;
      sb.push_back(e);
   endtask

   // Drives a one-cycle key_flag; returns the number of the edge that sampled it.
   task automatic key_ev(input logic st, output int e);
      e         = edge_n + 1;
      key_flag  = 1'b1;
      key_state = st;
      @(negedge Clk);
      key_flag  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic sb_drained(input string tag);
      check(tag, sb.size(), 0);
      sb.delete();
   endtask

   always @(negedge Clk) begin
      int   n;
      int   kind;
      exp_t e;
      n = int'(short_press) + int'(long_press) + int'(double_click) + int'(key_repeat);
      if (n != 0) begin
         if (n > 1) check("single_pulse", n, 1);
         kind = short_press ? K_SHORT : long_press ? K_LONG : double_click ? K_DOUBLE : K_REPEAT;
         if (sb.size() == 0) begin
            check("unexpected_pulse", kind, 0);
         end else begin
            e = sb.pop_front();
            check("pulse_kind", kind, e.kind);
            check("pulse_edge", edge_n, e.edge_no);
         end
      end
   end

   initial begin
      int p, r, x;

      @(negedge Clk);
      check("reset_busy", int'(busy), 0);
      check("reset_pulses", int'({short_press, long_press, double_click, key_repeat}), 0);
      Rst_n = 1'b1;
      idle(2);

      // Single click: short_press DCLK_CNT edges after the release.
      key_ev(1'b0, p);
      check("t1_busy_pressed", int'(busy), 1);
      idle(9);
      key_ev(1'b1, r);
      check("t1_release_edge", r - p, 10);
      push(K_SHORT, r + D);
      idle(29);
      check("t1_busy_wait2", int'(busy), 1);
      idle(1);
      check("t1_busy_done", int'(busy), 0);
      idle(5);
      sb_drained("t1_sb_drained");

      // Double click inside the window.
      key_ev(1'b0, p);
      idle(9);
      key_ev(1'b1, r);
      idle(4);
      key_ev(1'b0, x);
      idle(9);
      push(K_DOUBLE, edge_n + 1);
      key_ev(1'b1, r);
      check("t2_busy_after", int'(busy), 0);
      idle(40);
      sb_drained("t2_sb_drained");

      // Hold 250 cycles: long_press, optional repeats, silent release.
      key_ev(1'b0, p);
      push(K_LONG, p + L);
`ifdef KEY_REPEAT_EN
      for (int k = 1; k <= 7; k++) push(K_REPEAT, p + L + k * R);
`endif
      idle(248);
      check("t3_busy_held", int'(busy), 1);
      idle(1);
      key_ev(1'b1, r);
      check("t3_release_edge", r - p, 250);
      check("t3_busy_after", int'(busy), 0);
      idle(30);
      sb_drained("t3_sb_drained");

      // Release coincident with the long threshold: key_flag wins.
      key_ev(1'b0, p);
      idle(99);
      key_ev(1'b1, r);
      check("t4_busy_wait2", int'(busy), 1);
      push(K_SHORT, r + D);
      idle(40);
      sb_drained("t4_sb_drained");

      // Asynchronous reset in WAIT2 at cnt=20 discards the pending short_press.
      key_ev(1'b0, p);
      idle(9);
      key_ev(1'b1, r);
      idle(20);
      Rst_n = 1'b0;
      #1;
      check("t5_busy_in_reset", int'(busy), 0);
      check("t5_pulses_in_reset", int'({short_press, long_press, double_click, key_repeat}), 0);
      idle(3);
      Rst_n = 1'b1;
      idle(60);
      check("t5_busy_after", int'(busy), 0);
      sb_drained("t5_sb_drained");

      // Release in IDLE, then press while in LONG: both ignored.
      key_ev(1'b1, x);
      idle(1);
      check("t6_busy_idle_release", int'(busy), 0);
      idle(2);
      key_ev(1'b0, p);
      push(K_LONG, p + L);
`ifdef KEY_REPEAT_EN
      push(K_REPEAT, p + L + R);
`endif
      idle(109);
      key_ev(1'b0, x);
      check("t6_busy_long", int'(busy), 1);
      idle(13);
      key_ev(1'b1, r);
      idle(30);
      sb_drained("t6_sb_drained");

      // Redundant release in WAIT2 must not restart the window.
      key_ev(1'b0, p);
      idle(9);
      key_ev(1'b1, r);
      push(K_SHORT, r + D);
      idle(4);
      key_ev(1'b1, x);
      idle(40);
      sb_drained("t7_sb_drained");

      // Second press held past LONG_CNT still yields only double_click.
      key_ev(1'b0, p);
      idle(9);
      key_ev(1'b1, r);
      idle(4);
      key_ev(1'b0, x);
      idle(149);
      push(K_DOUBLE, edge_n + 1);
      key_ev(1'b1, r);
      idle(30);
      check("t8_busy_after", int'(busy), 0);
      sb_drained("t8_sb_drained");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
